// File: rtl/io_fifo_port.sv
// ============================================================================
// io_fifo_port
// ----------------------------------------------------------------------------
// Memory-mapped I/O port placed behind the data-memory/I/O decoder. CPU stores
// (io_write) are buffered in a TX FIFO toward an external device. Words from
// the device are buffered in an RX FIFO and returned to the CPU on loads
// (io_read). Both device-facing sides use valid/ready handshakes.
//
// Optional build macro: IO_PORT_LOOPBACK_EN
//   When defined, the TX head feeds the RX FIFO internally. External tx_valid
//   and rx_ready are tied low, and rx_valid/rx_data/tx_ready are ignored.
//   When undefined (the default), the external handshakes are used.
//
// Parameters
//   DEPTH        entries per FIFO (power of two, >= 2)
//   DATA_W       data width
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   io_write     store strobe, one push per cycle while high
//   io_read      load strobe, one pop per cycle while high
//   wdata        CPU store data
//   rdata        CPU load data (registered)
//   rdata_valid  rdata holds a popped RX word this cycle
//   tx_data      head of TX FIFO
//   tx_valid     TX FIFO not empty
//   tx_ready     device accepts tx_data
//   rx_data      device word
//   rx_valid     device offers rx_data
//   rx_ready     RX FIFO can accept
//   tx_overflow  sticky: a store was dropped
//   rx_underflow sticky: a load found RX empty
// ============================================================================
module io_fifo_port #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_write,
    input  logic              io_read,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              tx_overflow,
    output logic              rx_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage
    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [DATA_W-1:0] rx_mem [DEPTH];

    // TX FIFO state
    logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PTR_W-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CNT_W-1:0] tx_count_q,  tx_count_d;

    // RX FIFO state
    logic [PTR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [PTR_W-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CNT_W-1:0] rx_count_q,  rx_count_d;

    // CPU-side registered outputs
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_valid_q;
    logic              tx_overflow_q;
    logic              rx_underflow_q;

    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic              tx_push, tx_pop, tx_drop;
    logic              rx_push, rx_pop, rx_miss;
    logic [DATA_W-1:0] tx_head, rx_head, rx_push_data;

    assign tx_full  = (tx_count_q == FULL_CNT);
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == FULL_CNT);
    assign rx_empty = (rx_count_q == '0);

    assign tx_head  = tx_mem[tx_rd_ptr_q];
    assign rx_head  = rx_mem[rx_rd_ptr_q];

`ifdef IO_PORT_LOOPBACK_EN
    // Internal transfer: TX head moves straight into the RX FIFO.
    logic lb_xfer;
    logic unused_ext;

    assign lb_xfer      = !tx_empty && !rx_full;
    assign tx_pop       = lb_xfer;
    assign rx_push      = lb_xfer;
    assign rx_push_data = tx_head;
    assign tx_valid     = 1'b0;
    assign rx_ready     = 1'b0;
    assign unused_ext   = ^{rx_valid, rx_data, tx_ready};
`else
    assign tx_pop       = !tx_empty && tx_ready;
    assign rx_push      = rx_valid && !rx_full;
    assign rx_push_data = rx_data;
    assign tx_valid     = !tx_empty;
    assign rx_ready     = !rx_full;
`endif

    assign tx_data = tx_head;

    // A store into a full FIFO still succeeds when the head leaves this cycle.
    assign tx_push = io_write && (!tx_full || tx_pop);
    assign tx_drop = io_write && !tx_push;
    assign rx_pop  = io_read && !rx_empty;
    assign rx_miss = io_read && rx_empty;

    // Pointer and occupancy next-state. Pointers are PTR_W bits wide, so the
    // increment wraps modulo DEPTH naturally (DEPTH is a power of two).
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(1);
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + CNT_W'(1);
            2'b01:   tx_count_d = tx_count_q - CNT_W'(1);
            default: tx_count_d = tx_count_q;
        endcase
    end

    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PTR_W'(1);
        if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + CNT_W'(1);
            2'b01:   rx_count_d = rx_count_q - CNT_W'(1);
            default: rx_count_d = rx_count_q;
        endcase
    end

    // Storage writes; contents need no reset since occupancy gates all reads.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= wdata;
        if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_push_data;
    end

    // Control state: reset empties both FIFOs without waiting for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr_q    <= '0;
            tx_rd_ptr_q    <= '0;
            tx_count_q     <= '0;
            rx_wr_ptr_q    <= '0;
            rx_rd_ptr_q    <= '0;
            rx_count_q     <= '0;
            rdata_q        <= '0;
            rdata_valid_q  <= 1'b0;
            tx_overflow_q  <= 1'b0;
            rx_underflow_q <= 1'b0;
        end else begin
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_count_q    <= tx_count_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_count_q    <= rx_count_d;
            rdata_valid_q <= rx_pop;
            // A load from an empty RX returns zero; no load holds rdata.
            if (rx_pop) begin
                rdata_q <= rx_head;
            end else if (rx_miss) begin
                rdata_q <= '0;
            end
            if (tx_drop) tx_overflow_q  <= 1'b1;
            if (rx_miss) rx_underflow_q <= 1'b1;
        end
    end

    assign rdata        = rdata_q;
    assign rdata_valid  = rdata_valid_q;
    assign tx_overflow  = tx_overflow_q;
    assign rx_underflow = rx_underflow_q;

endmodule

// File: doc/io_fifo_port.md
# io_fifo_port

Memory-mapped I/O port peripheral sitting directly downstream of the data-memory/I/O control-signal decoder. It consumes one decoded `io_write`/`io_read` strobe pair plus the CPU store data, and buffers traffic between the MIPS core and an external device through a TX FIFO (CPU to device) and an RX FIFO (device to CPU). Both device-facing sides use valid/ready handshakes. One instance serves each I/O address (0x8000, 0x8004).

## Interface
- `DEPTH`, 4, entries per FIFO; power of two, at least 2
- `DATA_W`, 32, data width
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `io_write`  in  1  store strobe from the decoder; one push per cycle while high
- `io_read`  in  1  load strobe from the decoder; one pop per cycle while high
- `wdata`  in  DATA_W  CPU store data
- `rdata`  out  DATA_W  CPU load data, registered
- `rdata_valid`  out  1  `rdata` holds a popped RX word this cycle
- `tx_data`  out  DATA_W  head of the TX FIFO
- `tx_valid`  out  1  TX FIFO not empty
- `tx_ready`  in  1  device accepts `tx_data`
- `rx_data`  in  DATA_W  device word
- `rx_valid`  in  1  device offers `rx_data`
- `rx_ready`  out  1  RX FIFO can accept
- `tx_overflow`  out  1  sticky: a store was dropped
- `rx_underflow`  out  1  sticky: a load found RX empty

## Operation
- Each FIFO is a circular buffer with `$clog2(DEPTH)`-bit read/write pointers that wrap modulo DEPTH, plus a `$clog2(DEPTH)+1`-bit occupancy counter. full = (count == DEPTH). empty = (count == 0).
- TX push condition: `io_write` && (!full || pop in the same cycle). TX pop condition: `tx_valid && tx_ready`. A write to a full FIFO with no pop in that cycle discards the data and sets `tx_overflow`.
- RX push condition: `rx_valid && rx_ready`, with `rx_ready` = !RX full. A simultaneous RX push and pop is allowed.
- Load behaviour: on `io_read` with RX not empty, the block pops, sets `rdata` to the head word, and drives `rdata_valid` to 1. On `io_read` with RX empty, `rdata` is 0, `rdata_valid` is 0, and `rx_underflow` is set. With no `io_read`, `rdata_valid` is 0 and `rdata` holds its value.
- Simultaneous push and pop on the same FIFO leaves the count unchanged and advances both pointers.
- `io_write` and `io_read` may be high in the same cycle; the TX and RX paths act independently.
- Sticky flags clear only on reset.
- `tx_data` and `tx_valid` stay stable while `tx_valid && !tx_ready`.

## Timing
- Reset values: pointers = 0, counts = 0, `rdata` = 0, `rdata_valid` = 0, `tx_valid` = 0, `rx_ready` = 1, `tx_overflow` = 0, `rx_underflow` = 0. `tx_data` is don't-care while `tx_valid` = 0.
- Reset assertion mid-transfer empties both FIFOs immediately, without waiting for a clock edge. Words in flight are lost.
- Store-to-device latency: a word written at edge N appears on `tx_data` with `tx_valid` = 1 after edge N, provided the FIFO was empty.
- Load latency: 1 cycle. `rdata` is valid after the edge that samples `io_read`.
- Device-to-CPU latency: a word accepted at edge N is readable by an `io_read` sampled at edge N+1.
- Sustained throughput is 1 word per cycle in each direction.

## Configuration
- Macro: `IO_PORT_LOOPBACK_EN`.
- Defined: the TX head feeds the RX FIFO internally. A transfer occurs whenever TX is not empty and RX is not full. External `tx_valid` and `rx_ready` are tied to 0, and `rx_valid`, `rx_data`, and `tx_ready` are ignored.
- Undefined: the block uses the external handshakes as described above. No loopback logic is present.

## Test plan
- Reset, then write 0xA5A5_0001..0004 with `tx_ready` = 0 -> count reaches 4 and `tx_valid` = 1 with `tx_data` = 0xA5A5_0001. A fifth write of 0xDEAD_BEEF is dropped, `tx_overflow` = 1, and the following drain yields only the first four words, in order.
- Full TX, with `io_write` (0x1234) and `tx_ready` = 1 in the same cycle -> one word popped and 0x1234 accepted. Count stays 4, and 0x1234 emerges after three more pops.
- Device pushes 0x11, 0x22 (`rx_valid` = 1 for 2 cycles); then `io_read` for 3 cycles -> `rdata` = 0x11 then 0x22 with `rdata_valid` = 1, then 0 with `rdata_valid` = 0 and `rx_underflow` = 1.
- Push 6 words through a DEPTH = 4 RX FIFO, with interleaved reads -> pointers wrap past 3 and the data order is preserved.
- Assert `rst_n` = 0 asynchronously with 3 words in TX -> `tx_valid` falls to 0 before the next edge, and all outputs return to their reset values.
- With `IO_PORT_LOOPBACK_EN` defined: write 0xCAFE, wait 2 cycles, then `io_read` -> `rdata` = 0xCAFE with `rdata_valid` = 1, and external `tx_valid` stays 0 throughout.
